// File: rtl/cpuclk_phase_tracker.sv
// Tracks the MSX CPU-clock phase inside the x20 PLL domain and emits edge-aligned enables.
// Build option: define CPUCLK_FREERUN_EN to keep the enables running while unlocked.
module cpuclk_phase_tracker #(
  parameter int unsigned DIV        = 20,
  parameter int unsigned LOCK_COUNT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       msx_clk,
  output logic [4:0] phase,
  output logic       ce_rise,
  output logic       ce_fall,
  output logic       ce_div2,
  output logic       locked,
  output logic       err
);

  localparam int unsigned PW = 5;
  localparam int unsigned CW = 4;
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_EARLY = PW'(DIV - 2);
  localparam logic [PW-1:0] PH_MID   = PW'(DIV / 2);
  localparam logic [CW-1:0] CNT_LOCK = CW'(LOCK_COUNT);

  logic          s1;
  logic          s2;
  logic          s2_d;
  logic [CW-1:0] good_cnt;
  logic          half;

  logic          msx_edge;
  logic          at_last;
  logic          reload;
  logic          good;
  logic          bad;
  logic [PW-1:0] phase_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          locked_nxt;
  logic          lock_rise;
  logic          en_gate;
  logic          rise_nxt;
  logic          fall_nxt;
  logic          div2_nxt;
  logic          half_nxt;
  logic          err_nxt;

  // Edge validation, phase counter and enable decode
  always_comb begin
    msx_edge   = s2 & ~s2_d;
    at_last    = (phase == PH_LAST);
    reload     = msx_edge | at_last;
    // phase never exceeds DIV-1, so >= DIV-2 is the two-cycle acceptance window
    good       = msx_edge & (phase >= PH_EARLY);
    bad        = (msx_edge & ~good) | (~msx_edge & at_last);
    phase_nxt  = reload ? '0 : phase + PW'(1);

    cnt_nxt = good_cnt;
    if (bad) begin
      cnt_nxt = '0;
    end else if (good && (good_cnt < CNT_LOCK)) begin
      cnt_nxt = good_cnt + CW'(1);
    end

    locked_nxt = (cnt_nxt == CNT_LOCK);
    lock_rise  = locked_nxt & ~locked;

`ifdef CPUCLK_FREERUN_EN
    en_gate = 1'b1;
`else
    en_gate = locked_nxt;
`endif

    rise_nxt = reload & en_gate;
    fall_nxt = (phase_nxt == PH_MID) & en_gate;
    // the ce_rise that coincides with lock acquisition never carries ce_div2
    div2_nxt = rise_nxt & half & ~lock_rise;

    half_nxt = half;
    if (lock_rise) begin
      half_nxt = 1'b0;
    end else if (rise_nxt) begin
      half_nxt = ~half;
    end

    err_nxt = bad & locked;
  end

  // Two-flop synchroniser plus edge-detect delay
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= msx_clk;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  // Tracker state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= '0;
      good_cnt <= '0;
      half     <= 1'b0;
      locked   <= 1'b0;
      ce_rise  <= 1'b0;
      ce_fall  <= 1'b0;
      ce_div2  <= 1'b0;
      err      <= 1'b0;
    end else begin
      phase    <= phase_nxt;
      good_cnt <= cnt_nxt;
      half     <= half_nxt;
      locked   <= locked_nxt;
      ce_rise  <= rise_nxt;
      ce_fall  <= fall_nxt;
      ce_div2  <= div2_nxt;
      err      <= err_nxt;
    end
  end

endmodule
